// File: rtl/sc_backg_shift_sequencer.sv
// Sequencer for the background-type shift register: clear, load, then N prescaled rotate commands.
// Build option BACKGSEQ_LOOP_EN: reload the shift count and keep rotating until abort or reset.
module sc_backg_shift_sequencer #(
  parameter int unsigned BACKGSEQ_DATAWIDTH    = 8,
  parameter int unsigned BACKGSEQ_TICK_DIVIDER = 5000000,
  parameter int unsigned BACKGSEQ_TICK_WIDTH   = 23,
  parameter int unsigned BACKGSEQ_COUNT_WIDTH  = 4
) (
  input  logic                            SC_RegBACKGTYPE_CLOCK_50,
  input  logic                            SC_RegBACKGTYPE_RESET_InHigh,
  input  logic                            SC_BACKGSEQ_start_InLow,
  input  logic                            SC_BACKGSEQ_abort_InLow,
  input  logic                            SC_BACKGSEQ_pause_In,
  input  logic                            SC_BACKGSEQ_direction_In,
  input  logic [BACKGSEQ_COUNT_WIDTH-1:0] SC_BACKGSEQ_count_In,
  input  logic [BACKGSEQ_DATAWIDTH-1:0]   SC_BACKGSEQ_pattern_InBUS,
  output logic                            SC_BACKGSEQ_clear_OutLow,
  output logic                            SC_BACKGSEQ_load_OutLow,
  output logic [1:0]                      SC_BACKGSEQ_shiftselection_Out,
  output logic [BACKGSEQ_DATAWIDTH-1:0]   SC_BACKGSEQ_data_OutBUS,
  output logic                            SC_BACKGSEQ_busy_Out,
  output logic                            SC_BACKGSEQ_done_Out
);

  localparam logic [BACKGSEQ_TICK_WIDTH-1:0]  TICK_LAST = BACKGSEQ_TICK_WIDTH'(BACKGSEQ_TICK_DIVIDER - 1);
  localparam logic [BACKGSEQ_TICK_WIDTH-1:0]  TICK_ONE  = BACKGSEQ_TICK_WIDTH'(1);
  localparam logic [BACKGSEQ_COUNT_WIDTH-1:0] COUNT_ONE = BACKGSEQ_COUNT_WIDTH'(1);
  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  typedef enum logic [2:0] {
    STATE_IDLE,
    STATE_CLEAR,
    STATE_LOAD,
    STATE_WAIT,
    STATE_SHIFT,
    STATE_DONE
  } stateType;

  stateType                          state;
  logic [BACKGSEQ_TICK_WIDTH-1:0]    tickCount;
  logic [BACKGSEQ_COUNT_WIDTH-1:0]   remainingCount;
  logic [BACKGSEQ_COUNT_WIDTH-1:0]   capturedCount;
  logic                              capturedDirection;
  logic [BACKGSEQ_DATAWIDTH-1:0]     capturedPattern;

  // The data bus always presents the pattern captured at the last start.
  assign SC_BACKGSEQ_data_OutBUS = capturedPattern;

  // Outputs are registered alongside the state they decode, so they always match the state register.
  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      state                          <= STATE_IDLE;
      tickCount                      <= '0;
      remainingCount                 <= '0;
      capturedCount                  <= '0;
      capturedDirection              <= 1'b0;
      capturedPattern                <= '0;
      SC_BACKGSEQ_clear_OutLow       <= 1'b1;
      SC_BACKGSEQ_load_OutLow        <= 1'b1;
      SC_BACKGSEQ_shiftselection_Out <= SHIFT_NONE;
      SC_BACKGSEQ_busy_Out           <= 1'b0;
      SC_BACKGSEQ_done_Out           <= 1'b0;
    end else begin
      SC_BACKGSEQ_clear_OutLow       <= 1'b1;
      SC_BACKGSEQ_load_OutLow        <= 1'b1;
      SC_BACKGSEQ_shiftselection_Out <= SHIFT_NONE;
      SC_BACKGSEQ_busy_Out           <= 1'b0;
      SC_BACKGSEQ_done_Out           <= 1'b0;

      if (!SC_BACKGSEQ_abort_InLow) begin
        // Abort leaves the register untouched: no clear is issued on the way back to idle.
        state          <= STATE_IDLE;
        tickCount      <= '0;
        remainingCount <= '0;
      end else begin
        case (state)
          STATE_IDLE, STATE_DONE: begin
            if (!SC_BACKGSEQ_start_InLow) begin
              capturedPattern          <= SC_BACKGSEQ_pattern_InBUS;
              capturedDirection        <= SC_BACKGSEQ_direction_In;
              capturedCount            <= SC_BACKGSEQ_count_In;
              remainingCount           <= SC_BACKGSEQ_count_In;
              state                    <= STATE_CLEAR;
              SC_BACKGSEQ_clear_OutLow <= 1'b0;
              SC_BACKGSEQ_busy_Out     <= 1'b1;
            end else if (state == STATE_DONE) begin
              SC_BACKGSEQ_done_Out <= 1'b1;
            end
          end

          STATE_CLEAR: begin
            state                   <= STATE_LOAD;
            SC_BACKGSEQ_load_OutLow <= 1'b0;
            SC_BACKGSEQ_busy_Out    <= 1'b1;
          end

          STATE_LOAD: begin
            tickCount <= '0;
            if (capturedCount == '0) begin
              state                <= STATE_DONE;
              SC_BACKGSEQ_done_Out <= 1'b1;
            end else begin
              state                <= STATE_WAIT;
              SC_BACKGSEQ_busy_Out <= 1'b1;
            end
          end

          STATE_WAIT: begin
            SC_BACKGSEQ_busy_Out <= 1'b1;
            if (!SC_BACKGSEQ_pause_In) begin
              if (tickCount == TICK_LAST) begin
                tickCount                      <= '0;
                state                          <= STATE_SHIFT;
                SC_BACKGSEQ_shiftselection_Out <= capturedDirection ? SHIFT_RIGHT : SHIFT_LEFT;
              end else begin
                tickCount <= tickCount + TICK_ONE;
              end
            end
          end

          STATE_SHIFT: begin
            if (remainingCount == COUNT_ONE) begin
`ifdef BACKGSEQ_LOOP_EN
              remainingCount       <= capturedCount;
              state                <= STATE_WAIT;
              SC_BACKGSEQ_busy_Out <= 1'b1;
`else
              remainingCount       <= '0;
              state                <= STATE_DONE;
              SC_BACKGSEQ_done_Out <= 1'b1;
`endif
            end else begin
              remainingCount       <= remainingCount - COUNT_ONE;
              state                <= STATE_WAIT;
              SC_BACKGSEQ_busy_Out <= 1'b1;
            end
          end

          default: begin
            state <= STATE_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sc_backg_shift_sequencer.sv
// Randomized bench: expected per-cycle command timeline built from the sequencing rules, plus a downstream register model.
module tb_sc_backg_shift_sequencer;

  localparam int unsigned DW  = 8;
  localparam int unsigned DIV = 4;
  localparam int unsigned TW  = 3;
  localparam int unsigned CW  = 4;
  localparam int MAXCYC = 256;
  localparam int PAUSE_SPAN = 64;
`ifdef BACKGSEQ_LOOP_EN
  localparam bit LOOP_MODE = 1'b1;
`else
  localparam bit LOOP_MODE = 1'b0;
`endif

  localparam int K_IDLE  = 0;
  localparam int K_CLEAR = 1;
  localparam int K_LOAD  = 2;
  localparam int K_WAIT  = 3;
  localparam int K_SHIFT = 4;
  localparam int K_DONE  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          startN, abortN, pause, direction;
  logic [CW-1:0] count;
  logic [DW-1:0] patternBus;
  logic          clearN, loadN, busy, done;
  logic [1:0]    shiftSel;
  logic [DW-1:0] dataBus;

  int            totalChecks = 0;
  int            badChecks   = 0;
  logic [DW-1:0] lastPattern;
  bit            pauseVec[MAXCYC];
  logic [DW-1:0] regModel;

  always #5 clk = ~clk;

  sc_backg_shift_sequencer #(
    .BACKGSEQ_DATAWIDTH   (DW),
    .BACKGSEQ_TICK_DIVIDER(DIV),
    .BACKGSEQ_TICK_WIDTH  (TW),
    .BACKGSEQ_COUNT_WIDTH (CW)
  ) dut (
    .SC_RegBACKGTYPE_CLOCK_50      (clk),
    .SC_RegBACKGTYPE_RESET_InHigh  (rst),
    .SC_BACKGSEQ_start_InLow       (startN),
    .SC_BACKGSEQ_abort_InLow       (abortN),
    .SC_BACKGSEQ_pause_In          (pause),
    .SC_BACKGSEQ_direction_In      (direction),
    .SC_BACKGSEQ_count_In          (count),
    .SC_BACKGSEQ_pattern_InBUS     (patternBus),
    .SC_BACKGSEQ_clear_OutLow      (clearN),
    .SC_BACKGSEQ_load_OutLow       (loadN),
    .SC_BACKGSEQ_shiftselection_Out(shiftSel),
    .SC_BACKGSEQ_data_OutBUS       (dataBus),
    .SC_BACKGSEQ_busy_Out          (busy),
    .SC_BACKGSEQ_done_Out          (done)
  );

  // Downstream rotate register fed by the sequencer's commands.
  always @(posedge clk or posedge rst) begin
    if (rst)                  regModel <= '0;
    else if (!clearN)         regModel <= '0;
    else if (!loadN)          regModel <= dataBus;
    else if (shiftSel == 2'b01) regModel <= {regModel[DW-2:0], regModel[DW-1]};
    else if (shiftSel == 2'b10) regModel <= {regModel[0], regModel[DW-1:1]};
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] rotateBy(input logic [7:0] v, input bit right, input int n);
    int k;
    logic [15:0] d;
    k = n % 8;
    if (right) k = (8 - k) % 8;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  task automatic checkCycle(input int kind, input int k, input bit dir);
    int expSel;
    expSel = (kind == K_SHIFT) ? (dir ? 2 : 1) : 0;
    checkValue($sformatf("clear@%0d", k), 32'(clearN), 32'(kind == K_CLEAR ? 0 : 1));
    checkValue($sformatf("load@%0d", k),  32'(loadN),  32'(kind == K_LOAD ? 0 : 1));
    checkValue($sformatf("shiftsel@%0d", k), 32'(shiftSel), 32'(expSel));
    checkValue($sformatf("busy@%0d", k), 32'(busy),
               32'((kind == K_CLEAR || kind == K_LOAD || kind == K_WAIT || kind == K_SHIFT) ? 1 : 0));
    checkValue($sformatf("done@%0d", k), 32'(done), 32'(kind == K_DONE ? 1 : 0));
    checkValue($sformatf("data@%0d", k), 32'(dataBus), 32'(lastPattern));
  endtask

  task automatic fillPause(input bit randomPause);
    for (int j = 0; j < MAXCYC; j++)
      pauseVec[j] = randomPause && (j < PAUSE_SPAN) && (($urandom % 4) == 0);
  endtask

  // abortReq: -1 none, -2 random, otherwise the cycle index whose closing edge sees abort low.
  task automatic runSequence(input logic [7:0] pat, input bit dir, input logic [3:0] cnt,
                             input int abortReq, input bit junkStart);
    int tl[MAXCYC];
    int i, unp, left, endIdx, abortAt, len, shifts;
    for (int j = 0; j < MAXCYC; j++) tl[j] = K_DONE;
    tl[0] = K_CLEAR;
    tl[1] = K_LOAD;
    i = 2;
    left = int'(cnt);
    while (left > 0 && i < MAXCYC) begin
      unp = 0;
      while (unp < int'(DIV) && i < MAXCYC) begin
        tl[i] = K_WAIT;
        if (!pauseVec[i]) unp++;
        i++;
      end
      if (i < MAXCYC) begin
        tl[i] = K_SHIFT;
        i++;
      end
      left--;
      if (LOOP_MODE && left == 0) left = int'(cnt);
    end
    endIdx = i;

    abortAt = abortReq;
    if (abortReq == -2)
      abortAt = (($urandom % 4) == 0) ? 2 + int'($urandom % 32'(endIdx)) : -1;
    if (LOOP_MODE && cnt != 0 && abortAt < 0) abortAt = 60;
    if (abortAt > MAXCYC - 5) abortAt = MAXCYC - 5;
    if (abortAt >= 0)
      for (int j = abortAt + 1; j < MAXCYC; j++) tl[j] = K_IDLE;
    len = (abortAt >= 0) ? abortAt + 4 : endIdx + 3;
    if (len > MAXCYC) len = MAXCYC;

    startN = 1'b0; patternBus = pat; direction = dir; count = cnt; pause = 1'b0; abortN = 1'b1;
    @(negedge clk);
    lastPattern = pat;
    shifts = 0;
    for (int k = 0; k < len; k++) begin
      checkCycle(tl[k], k, dir);
      if (tl[k] == K_SHIFT) shifts++;
      // Start pulses while busy and scrambled inputs must have no effect.
      startN = !(junkStart && (k % 3 == 1) && tl[k] >= K_CLEAR && tl[k] <= K_SHIFT);
      patternBus = 8'($urandom);
      direction  = 1'($urandom);
      count      = 4'($urandom);
      pause      = pauseVec[k];
      abortN     = (k == abortAt) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    startN = 1'b1; abortN = 1'b1; pause = 1'b0;
    checkValue("regModel", 32'(regModel), 32'(rotateBy(pat, dir, shifts)));
  endtask

  initial begin
    startN = 1'b1; abortN = 1'b1; pause = 1'b0; direction = 1'b0;
    count = '0; patternBus = '0; lastPattern = '0;
    fillPause(1'b0);
    repeat (2) @(negedge clk);
    checkCycle(K_IDLE, -1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkCycle(K_IDLE, 0, 1'b0);

    // Rotate-left of 0x81 three times: register ends at 0x0C via 0x03, 0x06.
    runSequence(8'h81, 1'b0, 4'd3, -1, 1'b0);
    // Zero count: clear, load, straight to done.
    runSequence(8'hF0, 1'b0, 4'd0, -1, 1'b0);
    // Pause held for 10 cycles in the first wait delays only the first pulse.
    fillPause(1'b0);
    for (int j = 2; j < 12; j++) pauseVec[j] = 1'b1;
    runSequence(8'h3C, 1'b1, 4'd2, -1, 1'b0);
    fillPause(1'b0);
    // Abort mid-wait, then a run with start pulses while busy.
    runSequence(8'hA5, 1'b0, 4'd5, 4, 1'b0);
    runSequence(8'h5A, 1'b1, 4'd3, -1, 1'b1);
`ifdef BACKGSEQ_LOOP_EN
    runSequence(8'h81, 1'b0, 4'd2, 60, 1'b0);
`endif

    for (int r = 0; r < 20; r++) begin
      fillPause(1'b1);
      runSequence(8'($urandom), 1'($urandom), 4'($urandom), -2, 1'($urandom));
    end
    fillPause(1'b0);

    // Asynchronous reset between edges while waiting.
    startN = 1'b0; patternBus = 8'h77; count = 4'd4; direction = 1'b0;
    @(negedge clk);
    startN = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("busyBeforeReset", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 lastPattern = '0;
    checkCycle(K_IDLE, -2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkCycle(K_IDLE, -3, 1'b0);
    runSequence(8'hC3, 1'b1, 4'd1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/sc_backg_shift_sequencer.md
Name: sc_backg_shift_sequencer

Overview:
Control FSM that sits directly upstream of the background-type shift register. On a start command it clears the register, loads a captured pattern, then issues a programmed number of single-cycle rotate-left or rotate-right commands, spaced by a prescaler tick. It drives the register's clear, load, shift-select and data inputs, and reports busy/done status to the top-level game FSM.

Parameters:
BACKGSEQ_DATAWIDTH, 8, width of pattern bus; matches downstream register width.
BACKGSEQ_TICK_DIVIDER, 5000000, cycles spent in WAIT before each shift; legal range ≥1.
BACKGSEQ_TICK_WIDTH, 23, tick counter width; must hold TICK_DIVIDER-1.
BACKGSEQ_COUNT_WIDTH, 4, width of shift-count input; 0..15 shifts.

Ports:
SC_RegBACKGTYPE_CLOCK_50  in  1  system clock, 50 MHz
SC_RegBACKGTYPE_RESET_InHigh  in  1  asynchronous, active-high reset
SC_BACKGSEQ_start_InLow  in  1  start command, active low, sampled in IDLE/DONE only
SC_BACKGSEQ_abort_InLow  in  1  abort, active low, any state
SC_BACKGSEQ_pause_In  in  1  high freezes tick counter in WAIT
SC_BACKGSEQ_direction_In  in  1  0 = rotate left (01), 1 = rotate right (10)
SC_BACKGSEQ_count_In  in  COUNT_WIDTH  number of shifts
SC_BACKGSEQ_pattern_InBUS  in  DATAWIDTH  pattern to load
SC_BACKGSEQ_clear_OutLow  out  1  to register clear, active low
SC_BACKGSEQ_load_OutLow  out  1  to register load, active low
SC_BACKGSEQ_shiftselection_Out  out  2  to register shift select
SC_BACKGSEQ_data_OutBUS  out  DATAWIDTH  to register data input
SC_BACKGSEQ_busy_Out  out  1  high in CLEAR/LOAD/WAIT/SHIFT
SC_BACKGSEQ_done_Out  out  1  high in DONE

Behaviour:
- Reset (async, high): state=IDLE; tick counter, remaining count, captured pattern/direction = 0. Outputs: clear=1, load=1, shiftsel=00, data=0, busy=0, done=0.
- Outputs are Moore-decoded from the state register and change only after a clock edge. data_OutBUS is always the captured pattern.
- IDLE: all command outputs inactive. At an edge with start_InLow=0: capture pattern, direction and count, then go to CLEAR.
- CLEAR: clear_OutLow=0 for exactly 1 cycle, then LOAD.
- LOAD: load_OutLow=0 for exactly 1 cycle. Tick counter is zeroed. If captured count=0, go to DONE; else go to WAIT.
- WAIT: tick counter increments each cycle with pause=0 and holds with pause=1. When counter==TICK_DIVIDER-1 and pause=0: counter←0, then SHIFT. WAIT lasts TICK_DIVIDER unpaused cycles.
- SHIFT: shiftsel = 01 (dir 0) or 10 (dir 1) for exactly 1 cycle. Remaining count decrements by 1. If the decremented value is 0, go to DONE; else go to WAIT.
- Shift pulse period is TICK_DIVIDER+1 cycles. Exactly N pulses are issued for count N.
- DONE: done=1, busy=0, command outputs inactive. start_InLow=0 restarts: capture inputs, then CLEAR.
- start is ignored while busy. Inputs captured at start are immune to later input changes.
- abort_InLow=0 at any edge: next state IDLE, counters zeroed. abort has priority over start and over all transitions. No clear is issued, so register contents are left as-is.
- clear, load and shiftsel≠00 are mutually exclusive; at most one command is active per cycle.
- Reset asserted mid-operation forces reset values immediately, without waiting for a clock edge.

Optional Feature:
Macro: BACKGSEQ_LOOP_EN.
- Defined: in SHIFT, when the remaining count reaches 0, reload it from the captured count and return to WAIT. Rotation continues indefinitely until abort or reset. done is never asserted when count≠0; count=0 still goes to DONE.
- Undefined: behaviour exactly as above.

Test Plan:
All scenarios use TICK_DIVIDER=4 and COUNT_WIDTH=4.
1. Reset asserted between clock edges during WAIT -> all outputs go to reset values immediately. After release, state is IDLE, busy=0, done=0.
2. start low 1 cycle with pattern=8'h81, dir=0, count=3 -> clear low 1 cycle, then load low 1 cycle with data=8'h81. Then three shiftsel=01 pulses, 5 cycles apart. Then done=1. A downstream register model reads 8'h03, 8'h06, 8'h0C.
3. count=0, pattern=8'hF0 -> clear, load, DONE. shiftsel stays 00 throughout, done=1 two cycles after CLEAR is entered.
4. count=2, dir=1, pause held high for 10 cycles during the first WAIT -> first 10 pulse arrives 10 cycles later than in the unpaused case. Second pulse spacing remains 5.
5. abort low during WAIT of a count=5 run -> IDLE next cycle, busy=0, no further pulses. A start pulsed while busy in a separate run is ignored, and the run completes unchanged.
6. With BACKGSEQ_LOOP_EN defined: count=2, dir=0 -> more than 6 shift pulses observed at 5-cycle spacing with done=0 throughout. abort stops the pulses.
